// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared AHB-Lite encodings and arbitration mode codes for the
// two-master arbiter.
`default_nettype none

package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } ahb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ahb_arb_input_stage.sv
// ahb_arb_input_stage: holds one master's deferred address phase and muxes held/live
// control onto the effective outputs. Macro AHB_ARB_LOCK_EN keeps HMASTLOCK.
`default_nettype none

module ahb_arb_input_stage
  import ahb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic        capture,
  input  logic        replay,
  output logic        pend,
  output logic        req,
  output logic [31:0] eff_haddr,
  output logic [1:0]  eff_htrans,
  output logic        eff_hwrite,
  output logic [2:0]  eff_hsize,
  output logic [2:0]  eff_hburst,
  output logic [3:0]  eff_hprot,
  output logic        eff_hmastlock
);

  ahb_ctrl_t live;
  ahb_ctrl_t held;
  ahb_ctrl_t sel;
  logic      live_lock;

`ifdef AHB_ARB_LOCK_EN
  assign live_lock = hmastlock;
`else
  logic unused_lock;
  assign live_lock   = 1'b0;
  assign unused_lock = hmastlock;
`endif

  assign live = '{addr: haddr, trans: htrans, write: hwrite, size: hsize,
                  burst: hburst, prot: hprot, lock: live_lock};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      held <= '0;
    end else if (capture) begin
      pend <= 1'b1;
      held <= live;
    end else if (replay) begin
      pend <= 1'b0;
    end
  end

  assign req = pend | htrans[1];
  assign sel = pend ? held : live;

  assign eff_haddr     = sel.addr;
  assign eff_htrans    = sel.trans;
  assign eff_hwrite    = sel.write;
  assign eff_hsize     = sel.size;
  assign eff_hburst    = sel.burst;
  assign eff_hprot     = sel.prot;
  assign eff_hmastlock = sel.lock;

endmodule

`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two-master AHB-Lite arbiter with per-master capture/replay.
// Optional macro AHB_ARB_LOCK_EN passes HMASTLOCK through and lets it hold the grant.
`default_nettype none

module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ARB_MODE      = 1,
  parameter int DEFAULT_OWNER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        HMASTER
);

  localparam logic DEF_OWNER = DEFAULT_OWNER[0];

  logic        aown, down, dval, last;
  logic        pend0, pend1, req0, req1;
  logic        rdy0, rdy1, cap0, cap1, rep0, rep1;
  logic [31:0] addr0, addr1;
  logic [1:0]  trans0, trans1, bus_trans;
  logic        write0, write1, lock0, lock1, bus_lock;
  logic [2:0]  size0, size1, burst0, burst1, bus_burst;
  logic [3:0]  prot0, prot1;
  logic        hold, last_eff, next_own, next_last;

  // A master sees the slave's HREADY only while it owns the data phase;
  // otherwise a held request stalls it until its replayed beat completes.
  assign rdy0 = (dval && !down) ? HREADY : !pend0;
  assign rdy1 = (dval &&  down) ? HREADY : !pend1;

  assign cap0 = rdy0 && M0_HTRANS[1] && !pend0 && !(!aown && HREADY);
  assign cap1 = rdy1 && M1_HTRANS[1] && !pend1 && !( aown && HREADY);
  assign rep0 = pend0 && !aown && HREADY;
  assign rep1 = pend1 &&  aown && HREADY;

  ahb_arb_input_stage u_stage0 (
    .clk(HCLK), .rst(HRESET),
    .haddr(M0_HADDR), .htrans(M0_HTRANS), .hwrite(M0_HWRITE), .hsize(M0_HSIZE),
    .hburst(M0_HBURST), .hprot(M0_HPROT), .hmastlock(M0_HMASTLOCK),
    .capture(cap0), .replay(rep0), .pend(pend0), .req(req0),
    .eff_haddr(addr0), .eff_htrans(trans0), .eff_hwrite(write0), .eff_hsize(size0),
    .eff_hburst(burst0), .eff_hprot(prot0), .eff_hmastlock(lock0)
  );

  ahb_arb_input_stage u_stage1 (
    .clk(HCLK), .rst(HRESET),
    .haddr(M1_HADDR), .htrans(M1_HTRANS), .hwrite(M1_HWRITE), .hsize(M1_HSIZE),
    .hburst(M1_HBURST), .hprot(M1_HPROT), .hmastlock(M1_HMASTLOCK),
    .capture(cap1), .replay(rep1), .pend(pend1), .req(req1),
    .eff_haddr(addr1), .eff_htrans(trans1), .eff_hwrite(write1), .eff_hsize(size1),
    .eff_hburst(burst1), .eff_hprot(prot1), .eff_hmastlock(lock1)
  );

  assign bus_trans = aown ? trans1 : trans0;
  assign bus_burst = aown ? burst1 : burst0;
  assign bus_lock  = aown ? lock1  : lock0;

  assign HADDR   = aown ? addr1  : addr0;
  assign HWRITE  = aown ? write1 : write0;
  assign HSIZE   = aown ? size1  : size0;
  assign HBURST  = bus_burst;
  assign HPROT   = aown ? prot1  : prot0;
  assign HTRANS  = HRESET ? IDLE : bus_trans;
  assign HWDATA  = down ? M1_HWDATA : M0_HWDATA;
  assign HMASTER = aown;

`ifdef AHB_ARB_LOCK_EN
  assign HMASTLOCK = !HRESET && bus_lock;
`else
  assign HMASTLOCK = 1'b0;
`endif

  assign M0_HREADY = rdy0;
  assign M1_HREADY = rdy1;
  assign M0_HRESP  = (dval && !down) ? HRESP : 1'b0;
  assign M1_HRESP  = (dval &&  down) ? HRESP : 1'b0;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  // Bursts and locked sequences never lose the grant mid-stream.
  always_comb begin
    hold = bus_lock;
    if (HTRANS == SEQ || HTRANS == BUSY) hold = 1'b1;
    if (HTRANS == NONSEQ && bus_burst != HBURST_SINGLE) hold = 1'b1;
  end

  // The owner issuing an address phase on this edge counts as most recently granted.
  assign last_eff = HTRANS[1] ? aown : last;

  always_comb begin
    next_own = aown;
    if (!hold) begin
      if (ARB_MODE == ARB_FIXED) begin
        if (req0)      next_own = 1'b0;
        else if (req1) next_own = 1'b1;
      end else begin
        if (last_eff ? req0 : req1)      next_own = !last_eff;
        else if (last_eff ? req1 : req0) next_own = last_eff;
      end
    end
    next_last = (next_own != aown) ? next_own : last_eff;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      aown <= DEF_OWNER;
      down <= DEF_OWNER;
      dval <= 1'b0;
      last <= !DEF_OWNER;
    end else if (HREADY) begin
      dval <= HTRANS[1];
      down <= aown;
      aown <= next_own;
      last <= next_last;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed checks of the arbiter with a round-robin DUT and a
// fixed-priority DUT driven by the same stimulus.
`default_nettype none

module tb_ahb_master_arbiter;
  import ahb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        hready, hresp;

  logic [31:0] m0_hrdata, m1_hrdata, haddr, hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [1:0]  htrans;
  logic        hwrite, hmastlock, hmaster;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  logic [31:0] fx_m0_hrdata, fx_m1_hrdata, fx_haddr, fx_hwdata;
  logic        fx_m0_hready, fx_m1_hready, fx_m0_hresp, fx_m1_hresp;
  logic [1:0]  fx_htrans;
  logic        fx_hwrite, fx_hmastlock, fx_hmaster;
  logic [2:0]  fx_hsize, fx_hburst;
  logic [3:0]  fx_hprot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.ARB_MODE(1), .DEFAULT_OWNER(0)) dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HBURST(m0_hburst), .M0_HPROT(m0_hprot), .M0_HMASTLOCK(m0_hmastlock),
    .M0_HWDATA(m0_hwdata), .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HBURST(m1_hburst), .M1_HPROT(m1_hprot), .M1_HMASTLOCK(m1_hmastlock),
    .M1_HWDATA(m1_hwdata), .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADY(hready), .HRESP(hresp), .HMASTER(hmaster)
  );

  ahb_master_arbiter #(.ARB_MODE(0), .DEFAULT_OWNER(0)) dut_fx (
    .HCLK(clk), .HRESET(rst),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HBURST(m0_hburst), .M0_HPROT(m0_hprot), .M0_HMASTLOCK(m0_hmastlock),
    .M0_HWDATA(m0_hwdata), .M0_HRDATA(fx_m0_hrdata), .M0_HREADY(fx_m0_hready),
    .M0_HRESP(fx_m0_hresp),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HBURST(m1_hburst), .M1_HPROT(m1_hprot), .M1_HMASTLOCK(m1_hmastlock),
    .M1_HWDATA(m1_hwdata), .M1_HRDATA(fx_m1_hrdata), .M1_HREADY(fx_m1_hready),
    .M1_HRESP(fx_m1_hresp),
    .HADDR(fx_haddr), .HTRANS(fx_htrans), .HWRITE(fx_hwrite), .HSIZE(fx_hsize),
    .HBURST(fx_hburst), .HPROT(fx_hprot), .HMASTLOCK(fx_hmastlock), .HWDATA(fx_hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HMASTER(fx_hmaster)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_htrans = IDLE; m1_htrans = IDLE;
    m0_hburst = HBURST_SINGLE; m1_hburst = HBURST_SINGLE;
    m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0;
  endtask

  task automatic do_reset();
    idle_masters();
    hready = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_haddr = '0; m1_haddr = '0; m0_hwdata = '0; m1_hwdata = '0;
    m0_hsize = 3'b010; m1_hsize = 3'b010; m0_hprot = 4'h3; m1_hprot = 4'h3;
    hrdata = 32'hCAFE_0001; hresp = 1'b0;
    idle_masters();
    hready = 1'b1;
    rst = 1'b1;
    cyc(); #1;
    check("rst_m0_hready", m0_hready, 1);
    check("rst_m1_hready", m1_hready, 1);
    check("rst_htrans", htrans, IDLE);
    check("rst_hmaster", hmaster, 0);
    check("rst_m0_hresp", m0_hresp, 0);
    check("rst_m1_hrdata", m1_hrdata, 32'hCAFE_0001);
    cyc();
    rst = 1'b0;

    // M0 single read, M1 idle
    m0_htrans = NONSEQ; m0_haddr = 32'h0000_0010; #1;
    check("t1_htrans", htrans, NONSEQ);
    check("t1_haddr", haddr, 32'h0000_0010);
    check("t1_hsize", hsize, 3'b010);
    check("t1_hmaster", hmaster, 0);
    check("t1_m1_hready", m1_hready, 1);
    cyc();
    m0_htrans = IDLE; hready = 1'b0; #1;
    check("t1_m0_hready_wait", m0_hready, 0);
    check("t1_m1_hready_wait", m1_hready, 1);
    cyc();
    hready = 1'b1; #1;
    check("t1_m0_hready_done", m0_hready, 1);
    check("t1_m0_hrdata", m0_hrdata, 32'hCAFE_0001);
    cyc();

    // M1 write while M0 parked: captured then replayed
    m1_htrans = NONSEQ; m1_haddr = 32'h5000_0000; m1_hwrite = 1'b1; #1;
    check("t2_m1_hready_acc", m1_hready, 1);
    check("t2_hmaster_c0", hmaster, 0);
    check("t2_htrans_c0", htrans, IDLE);
    cyc();
    m1_htrans = IDLE; m1_hwdata = 32'hA5A5_A5A5; #1;
    check("t2_m1_hready_held", m1_hready, 0);
    check("t2_hmaster_c1", hmaster, 1);
    check("t2_htrans_c1", htrans, NONSEQ);
    check("t2_haddr_c1", haddr, 32'h5000_0000);
    check("t2_hwrite_c1", hwrite, 1);
    cyc();
    hresp = 1'b1; #1;
    check("t2_m1_hready_data", m1_hready, 1);
    check("t2_hwdata", hwdata, 32'hA5A5_A5A5);
    check("t2_m1_hresp", m1_hresp, 1);
    check("t2_m0_hresp", m0_hresp, 0);
    hresp = 1'b0;
    cyc();
    do_reset();

    // Simultaneous NONSEQ from both masters, both keep requesting
    m0_htrans = NONSEQ; m0_haddr = 32'h0000_0100;
    m1_htrans = NONSEQ; m1_haddr = 32'h0000_0200; #1;
    check("t3_rr_hmaster_c1", hmaster, 0);
    check("t3_rr_haddr_c1", haddr, 32'h0000_0100);
    check("t3_fx_m1_hready_c1", fx_m1_hready, 1);
    cyc(); #1;
    check("t3_rr_hmaster_c2", hmaster, 1);
    check("t3_rr_haddr_c2", haddr, 32'h0000_0200);
    check("t3_rr_m1_hready_c2", m1_hready, 0);
    check("t3_fx_hmaster_c2", fx_hmaster, 0);
    check("t3_fx_m1_hready_c2", fx_m1_hready, 0);
    cyc(); #1;
    check("t3_rr_hmaster_c3", hmaster, 0);
    check("t3_rr_haddr_c3", haddr, 32'h0000_0100);
    check("t3_rr_m0_hready_c3", m0_hready, 0);
    check("t3_fx_hmaster_c3", fx_hmaster, 0);
    check("t3_fx_haddr_c3", fx_haddr, 32'h0000_0100);
    cyc(); #1;
    check("t3_rr_hmaster_c4", hmaster, 1);
    check("t3_fx_m1_hready_c4", fx_m1_hready, 0);
    cyc();
    idle_masters();
    repeat (4) cyc();
    do_reset();

    // M0 INCR4 burst with M1 requesting
    m0_htrans = NONSEQ; m0_hburst = 3'b011; m0_haddr = 32'h0000_1000;
    m1_htrans = NONSEQ; m1_haddr = 32'h0000_2000; #1;
    check("t4_hburst", hburst, 3'b011);
    cyc();
    m0_htrans = SEQ; m0_haddr = 32'h0000_1004; m1_htrans = IDLE; #1;
    check("t4_hmaster_b2", hmaster, 0);
    check("t4_m1_hready_b2", m1_hready, 0);
    cyc();
    m0_haddr = 32'h0000_1008;
    cyc();
    m0_haddr = 32'h0000_100C; #1;
    check("t4_hmaster_b4", hmaster, 0);
    cyc();
    m0_htrans = IDLE; m0_hburst = HBURST_SINGLE; #1;
    check("t4_hmaster_after", hmaster, 0);
    cyc(); #1;
    check("t4_hmaster_m1", hmaster, 1);
    check("t4_haddr_m1", haddr, 32'h0000_2000);
    check("t4_htrans_m1", htrans, NONSEQ);
    repeat (3) cyc();
    do_reset();

    // Lock behaviour
    m0_htrans = NONSEQ; m0_haddr = 32'h0000_3000; m0_hmastlock = 1'b1;
    m1_htrans = NONSEQ; m1_haddr = 32'h0000_4000; #1;
`ifdef AHB_ARB_LOCK_EN
    check("t5_hmastlock", hmastlock, 1);
    cyc();
    m0_haddr = 32'h0000_3004; m1_htrans = IDLE; #1;
    check("t5_lock_hmaster_c2", hmaster, 0);
    check("t5_lock_haddr_c2", haddr, 32'h0000_3004);
    cyc();
    m0_htrans = IDLE; m0_hmastlock = 1'b0; #1;
    check("t5_lock_hmaster_c3", hmaster, 0);
    cyc(); #1;
    check("t5_lock_hmaster_c4", hmaster, 1);
    check("t5_lock_haddr_c4", haddr, 32'h0000_4000);
`else
    check("t5_hmastlock_off", hmastlock, 0);
    cyc();
    m0_haddr = 32'h0000_3004; m1_htrans = IDLE; #1;
    check("t5_nolock_hmaster_c2", hmaster, 1);
    check("t5_nolock_haddr_c2", haddr, 32'h0000_4000);
    cyc();
    m0_htrans = IDLE; m0_hmastlock = 1'b0; #1;
    check("t5_nolock_hmaster_c3", hmaster, 0);
    check("t5_nolock_haddr_c3", haddr, 32'h0000_3004);
`endif
    idle_masters();
    repeat (3) cyc();
    do_reset();

    // Wait states during M1 data phase, M0 captured and replayed
    m1_htrans = NONSEQ; m1_haddr = 32'h5000_0010; m1_hwrite = 1'b1;
    cyc();
    m1_htrans = IDLE; m1_hwdata = 32'h1111_2222; #1;
    check("t6_hmaster_m1", hmaster, 1);
    check("t6_htrans_m1", htrans, NONSEQ);
    cyc();
    hready = 1'b0; m0_htrans = NONSEQ; m0_haddr = 32'h0000_6000; #1;
    check("t6_m1_hready_w1", m1_hready, 0);
    check("t6_m0_hready_w1", m0_hready, 1);
    check("t6_hmaster_w1", hmaster, 1);
    cyc();
    m0_htrans = IDLE; #1;
    check("t6_m0_hready_w2", m0_hready, 0);
    check("t6_hmaster_w2", hmaster, 1);
    check("t6_htrans_w2", htrans, IDLE);
    cyc(); #1;
    check("t6_hmaster_w3", hmaster, 1);
    check("t6_m1_hready_w3", m1_hready, 0);
    cyc();
    hready = 1'b1; #1;
    check("t6_m1_hready_done", m1_hready, 1);
    check("t6_hmaster_done", hmaster, 1);
    cyc(); #1;
    check("t6_hmaster_replay", hmaster, 0);
    check("t6_haddr_replay", haddr, 32'h0000_6000);
    check("t6_htrans_replay", htrans, NONSEQ);
    check("t6_m0_hready_replay", m0_hready, 0);
    cyc(); #1;
    check("t6_m0_hready_data", m0_hready, 1);
    repeat (2) cyc();
    do_reset();

    // Same setup, reset asserted during the wait states
    m1_htrans = NONSEQ; m1_haddr = 32'h5000_0010; m1_hwrite = 1'b1;
    cyc();
    m1_htrans = IDLE;
    cyc();
    hready = 1'b0; m0_htrans = NONSEQ; m0_haddr = 32'h0000_6000;
    cyc();
    m0_htrans = IDLE; #1;
    check("t7_m0_pending", m0_hready, 0);
    cyc();
    rst = 1'b1; m0_htrans = NONSEQ; #1;
    check("t7_rst_m0_hready", m0_hready, 1);
    check("t7_rst_m1_hready", m1_hready, 1);
    check("t7_rst_htrans", htrans, IDLE);
    cyc();
    m0_htrans = IDLE; hready = 1'b1; rst = 1'b0; #1;
    check("t7_post_m0_hready", m0_hready, 1);
    check("t7_post_hmaster", hmaster, 0);
    check("t7_post_htrans", htrans, IDLE);
    cyc(); #1;
    check("t7_no_replay", htrans, IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
